// File: rtl/id_ex_forward_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_forward_stage_if
// Bundle between the hazard unit / ID decode side and the ID/EX forwarding
// stage.
//   master : hazard unit + ID side. Drives the selects, stall/flush requests,
//            register file data, forwarding sources and ID control. Observes
//            the EX-side registers and the strobes.
//   slave  : the forwarding stage itself.
// Optional HAZARD_PERF_EN adds perf_stall_cnt/perf_flush_cnt/perf_fwd_cnt.
// ---------------------------------------------------------------------------
interface id_ex_forward_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic [1:0]        ISA, ISB, ISC;
  logic              stall_pipeline;
  logic              flush_pipeline;
  logic [DATA_W-1:0] RA_data, RB_data, RC_data;
  logic [DATA_W-1:0] EX_result, MEM_result, WB_result;
  logic [CTRL_W-1:0] ctrl_ID;
  logic [3:0]        RW_ID;
  logic              valid_ID;

  logic [DATA_W-1:0] A_EX, B_EX, C_EX;
  logic [CTRL_W-1:0] ctrl_EX;
  logic [3:0]        RW_EX;
  logic              valid_EX;
  logic              pc_ld;
  logic              ifid_ld;
  logic              ifid_clr;
  logic              stall_err;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
  logic [31:0]       perf_fwd_cnt;
`endif

  modport master (
    output ISA, ISB, ISC, stall_pipeline, flush_pipeline,
    output RA_data, RB_data, RC_data, EX_result, MEM_result, WB_result,
    output ctrl_ID, RW_ID, valid_ID,
    input  A_EX, B_EX, C_EX, ctrl_EX, RW_EX, valid_EX,
    input  pc_ld, ifid_ld, ifid_clr, stall_err
`ifdef HAZARD_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt
`endif
  );

  modport slave (
    input  ISA, ISB, ISC, stall_pipeline, flush_pipeline,
    input  RA_data, RB_data, RC_data, EX_result, MEM_result, WB_result,
    input  ctrl_ID, RW_ID, valid_ID,
    output A_EX, B_EX, C_EX, ctrl_EX, RW_EX, valid_EX,
    output pc_ld, ifid_ld, ifid_clr, stall_err
`ifdef HAZARD_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt
`endif
  );
endinterface

// File: rtl/id_ex_forward_stage.sv
// ---------------------------------------------------------------------------
// id_ex_forward_stage
// Applies the hazard unit's forwarding selects to the three ID operands and
// registers them, with the ID control bundle, into the ID/EX register. It
// also turns stall/flush requests into PC / IF/ID strobes and inserts bubbles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : id_ex_forward_stage_if.slave. Selects (00=RF 01=EX 10=MEM 11=WB),
//           stall/flush requests, operand sources and ID control in; the
//           registered EX operands/control, pc_ld/ifid_ld/ifid_clr
//           (combinational) and the sticky stall_err out.
// Optional feature macro: HAZARD_PERF_EN (adds three 32-bit perf counters).
// ---------------------------------------------------------------------------
module id_ex_forward_stage #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 16,
  parameter int MAX_STALL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  id_ex_forward_stage_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_STALL) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ERR_AT  = CNT_W'(MAX_STALL + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_base;
  logic              err_reg, err_next;
  logic              pc_ld_c, ifid_ld_c, ifid_clr_c;

  logic [DATA_W-1:0] a_reg, b_reg, c_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [3:0]        rw_reg;
  logic              valid_reg;

  // Per-operand forwarding mux
  logic [1:0]        sel     [3];
  logic [DATA_W-1:0] rf_data [3];
  logic [DATA_W-1:0] fwd     [3];

  assign sel[0]     = bus.ISA;
  assign sel[1]     = bus.ISB;
  assign sel[2]     = bus.ISC;
  assign rf_data[0] = bus.RA_data;
  assign rf_data[1] = bus.RB_data;
  assign rf_data[2] = bus.RC_data;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_fwd
      assign fwd[gi] = sel[gi][1] ? (sel[gi][0] ? bus.WB_result : bus.MEM_result)
                                  : (sel[gi][0] ? bus.EX_result : rf_data[gi]);
    end
  endgenerate

  // The stall run count only carries over while already in STALL; a fresh
  // stall starts from zero, so the first stalled cycle counts as 1.
  assign cnt_base = (state_reg == STALL) ? cnt_reg : '0;

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    err_next   = err_reg;
    pc_ld_c    = 1'b1;
    ifid_ld_c  = 1'b1;
    ifid_clr_c = 1'b0;

    case (state_reg)
      RUN:     if (bus.stall_pipeline)  state_next = STALL;
      STALL:   if (!bus.stall_pipeline) state_next = RUN;
      default: state_next = RUN;
    endcase

    if (bus.stall_pipeline) begin
      // Stall has priority: a simultaneous flush is dropped and re-raised
      // later by the hazard unit.
      pc_ld_c   = 1'b0;
      ifid_ld_c = 1'b0;
      cnt_next  = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + 1'b1;
      if (cnt_next >= ERR_AT) err_next = 1'b1;
    end else begin
      ifid_clr_c = bus.flush_pipeline;
    end

    if (reset) begin
      pc_ld_c    = 1'b1;
      ifid_ld_c  = 1'b1;
      ifid_clr_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      ctrl_reg  <= '0;
      rw_reg    <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      if (bus.stall_pipeline) begin
        a_reg     <= '0;
        b_reg     <= '0;
        c_reg     <= '0;
        ctrl_reg  <= '0;
        rw_reg    <= '0;
        valid_reg <= 1'b0;
      end else begin
        a_reg     <= fwd[0];
        b_reg     <= fwd[1];
        c_reg     <= fwd[2];
        ctrl_reg  <= bus.valid_ID ? bus.ctrl_ID : '0;
        rw_reg    <= bus.valid_ID ? bus.RW_ID : 4'd0;
        valid_reg <= bus.valid_ID;
      end
    end
  end

  assign bus.A_EX      = a_reg;
  assign bus.B_EX      = b_reg;
  assign bus.C_EX      = c_reg;
  assign bus.ctrl_EX   = ctrl_reg;
  assign bus.RW_EX     = rw_reg;
  assign bus.valid_EX  = valid_reg;
  assign bus.pc_ld     = pc_ld_c;
  assign bus.ifid_ld   = ifid_ld_c;
  assign bus.ifid_clr  = ifid_clr_c;
  assign bus.stall_err = err_reg;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_reg, perf_flush_reg, perf_fwd_reg;
  logic        any_fwd;

  assign any_fwd = (|bus.ISA) | (|bus.ISB) | (|bus.ISC);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
      perf_fwd_reg   <= '0;
    end else begin
      if (bus.stall_pipeline) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (!bus.stall_pipeline && bus.flush_pipeline)
        perf_flush_reg <= perf_flush_reg + 32'd1;
      if (!bus.stall_pipeline && bus.valid_ID && any_fwd)
        perf_fwd_reg <= perf_fwd_reg + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_reg;
  assign bus.perf_flush_cnt = perf_flush_reg;
  assign bus.perf_fwd_cnt   = perf_fwd_reg;
`endif
endmodule
